io_port_unit: RTL and testbench
===============================

Name: io_port_unit

Overview:
- Peripheral I/O stage of the simple machine, directly downstream of the control unit.
- Services the IN and OUT instructions. The control unit's IN state pulses io_rd; its OUT state pulses io_wr.
- Decouples the single-cycle IN/OUT states from slow external devices using two small FIFOs with valid/ready handshakes.
- The control unit has no stall input, so every CPU-side access completes in the same cycle and errors are reported through sticky flags.

Parameters:
- DATA_W, 16, word width of the datapath bus and the external data ports.
- DEPTH, 4, entries per FIFO; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- io_rd  input  1  IN-state strobe from the control unit; pops the input FIFO.
- io_wr  input  1  OUT-state strobe from the control unit; pushes wdata into the output FIFO.
- wdata  input  DATA_W  datapath bus value to be written out.
- rdata  output  DATA_W  input-FIFO head value presented to the datapath (combinational).
- clr_flags  input  1  synchronous clear of both sticky error flags.
- ext_in_data  input  DATA_W  data from the external device.
- ext_in_valid  input  1  external device offers ext_in_data.
- ext_in_ready  output  1  unit can accept an input word.
- ext_out_data  output  DATA_W  output-FIFO head value.
- ext_out_valid  output  1  output FIFO is not empty.
- ext_out_ready  input  1  external device accepts ext_out_data.
- in_count  output  CNT_W  input-FIFO occupancy.
- out_count  output  CNT_W  output-FIFO occupancy.
- in_underrun  output  1  sticky flag: io_rd occurred while the input FIFO was empty.
- out_overrun  output  1  sticky flag: io_wr was dropped because the output FIFO was full.

Behaviour:
- Reset (asynchronous, rst high):
  - Both FIFOs are empty, pointers and counts are 0, sticky flags are 0.
  - Outputs: ext_in_ready=1, ext_out_valid=0, rdata=0, ext_out_data=0.
  - Storage contents are don't-care; when a FIFO is empty its head output is forced to 0.
- Input path:
  - ext_in_ready = (in_count != DEPTH), computed combinationally from registered state.
  - Push when ext_in_valid && ext_in_ready. The word becomes visible on rdata the next cycle; there is no same-cycle bypass.
  - rdata = head entry when in_count != 0, else 0 (show-ahead, zero latency). This lets the control unit's single IN state capture it in that same cycle.
  - On io_rd with in_count != 0: pop at the clock edge.
  - On io_rd with in_count == 0: no pop, rdata=0, in_underrun <= 1.
  - Push and pop in the same cycle with in_count in 1..DEPTH-1: both happen and the count is unchanged.
  - Push and pop in the same cycle when empty: the push succeeds, the pop underruns, and the count ends at 1.
  - When full, ready=0, so a simultaneous io_rd pops only.
- Output path:
  - ext_out_valid = (out_count != 0); ext_out_data = head entry, else 0.
  - Pop when ext_out_valid && ext_out_ready.
  - Push on io_wr when out_count != DEPTH, or when out_count == DEPTH and a pop occurs in the same cycle (pass-through at full; count stays at DEPTH).
  - io_wr at full with no pop: the word is dropped and out_overrun <= 1.
  - The external device must hold ext_out_data/valid stable until ready; the unit guarantees ext_out_data does not change while valid=1 and ready=0.
- Flags:
  - Set conditions take priority over clr_flags in the same cycle.
  - Flags remain set until clr_flags or rst.
- io_rd and io_wr asserted together is legal; the two paths are fully independent.
- Pointers: each pointer has log2(DEPTH) bits and wraps modulo DEPTH; the counts saturate naturally at DEPTH, with no overflow past DEPTH.
- rst asserted mid-transfer discards all queued data immediately; no handshake completes in the cycle where rst is high.

Decomposition:
- Shared header (io_defs.vh):
  - DATA_W default.
  - DEPTH default.
  - Control-word bit positions for the io_rd and io_wr strobes, so that the control unit and this block agree.
- One sub-module, sync_fifo:
  - Parameters: DATA_W, DEPTH.
  - Ports: push, pop, din, dout (show-ahead, 0 when empty), count, full, empty.
  - Pass-through at full is an allowed push when pop is high.
  - Instantiated twice: input FIFO and output FIFO.
- The top level adds the handshake glue and the sticky flags.

Test Plan:
- Reset then idle -> ext_in_ready=1, ext_out_valid=0, rdata=0, both counts 0, both flags 0.
- Push 0x1111, 0x2222, 0x3333 via ext_in, then three io_rd pulses -> rdata reads 0x1111, 0x2222, 0x3333 in order; in_count goes 3,2,1,0; a fourth io_rd -> rdata=0 and in_underrun=1; clr_flags -> in_underrun=0.
- Fill the input FIFO with 4 words -> ext_in_ready=0. A 5th offered word with valid held stays pending; io_rd pops 1 -> ready=1 the next cycle and the pending word is accepted; in_count stays at 4.
- ext_out_ready=0 and five io_wr of 0xA000..0xA004 -> out_count=4, out_overrun=1, 0xA004 lost. Then ready=1 -> 0xA000..0xA003 emerge on consecutive cycles and valid drops afterwards.
- Output FIFO full with ext_out_ready=1 and io_wr=0xBEEF in the same cycle -> the pop and push both occur, out_count stays 4, no overrun, and 0xBEEF is the last word drained.
- rst pulsed asynchronously mid-drain with 2 words queued -> counts go to 0 immediately, ext_out_valid=0, and rdata and ext_out_data read 0 before the next clock edge.

Source files
------------

// File: rtl/io_port_unit_pkg.sv
// rtl/io_port_unit_pkg.sv - shared defaults and control-word strobe positions for the I/O port unit
package io_port_unit_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_DEPTH  = 4;

    // Control-word layout shared with the control unit
    localparam int CTRL_W         = 16;
    localparam int CTRL_IO_RD_BIT = 12;
    localparam int CTRL_IO_WR_BIT = 13;

    typedef struct packed {
        logic in_underrun;
        logic out_overrun;
    } io_flags_t;

    function automatic logic ctrl_io_rd(input logic [CTRL_W-1:0] cw);
        return cw[CTRL_IO_RD_BIT];
    endfunction

    function automatic logic ctrl_io_wr(input logic [CTRL_W-1:0] cw);
        return cw[CTRL_IO_WR_BIT];
    endfunction

endpackage

// File: rtl/io_port_unit_sync_fifo.sv
// rtl/io_port_unit_sync_fifo.sv - show-ahead synchronous FIFO with pass-through push at full
module sync_fifo
    import io_port_unit_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// rtl/io_port_unit.sv - IN/OUT instruction I/O stage: two FIFOs, handshake glue and sticky error flags
module io_port_unit
    import io_port_unit_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              clr_flags,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    output logic [CNT_W-1:0]  in_count,
    output logic [CNT_W-1:0]  out_count,
    output logic              in_underrun,
    output logic              out_overrun
);

    logic      in_full;
    logic      in_empty;
    logic      in_push;
    logic      out_full;
    logic      out_empty;
    logic      out_pop;
    io_flags_t flags;
    io_flags_t flags_next;

    assign ext_in_ready  = !in_full;
    assign in_push       = ext_in_valid && ext_in_ready;
    assign ext_out_valid = !out_empty;
    assign out_pop       = ext_out_valid && ext_out_ready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_push),
        .pop   (io_rd),
        .din   (ext_in_data),
        .dout  (rdata),
        .count (in_count),
        .full  (in_full),
        .empty (in_empty)
    );

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (io_wr),
        .pop   (out_pop),
        .din   (wdata),
        .dout  (ext_out_data),
        .count (out_count),
        .full  (out_full),
        .empty (out_empty)
    );

    // Setting an error wins over a clear arriving in the same cycle
    always_comb begin
        flags_next             = flags;
        flags_next.in_underrun = (io_rd && in_empty)
                               || (flags.in_underrun && !clr_flags);
        flags_next.out_overrun = (io_wr && out_full && !out_pop)
                               || (flags.out_overrun && !clr_flags);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
        end else begin
            flags <= flags_next;
        end
    end

    assign in_underrun = flags.in_underrun;
    assign out_overrun = flags.out_overrun;

endmodule

// File: tb/tb_io_port_unit.sv
// tb/tb_io_port_unit.sv - self-checking bench for io_port_unit with a queue-based reference model
module tb_io_port_unit;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              io_rd = 1'b0;
    logic              io_wr = 1'b0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              clr_flags = 1'b0;
    logic [DATA_W-1:0] ext_in_data = '0;
    logic              ext_in_valid = 1'b0;
    logic              ext_in_ready;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready = 1'b0;
    logic [CNT_W-1:0]  in_count;
    logic [CNT_W-1:0]  out_count;
    logic              in_underrun;
    logic              out_overrun;

    int checks = 0;
    int errors = 0;

    io_port_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .io_rd         (io_rd),
        .io_wr         (io_wr),
        .wdata         (wdata),
        .rdata         (rdata),
        .clr_flags     (clr_flags),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .in_count      (in_count),
        .out_count     (out_count),
        .in_underrun   (in_underrun),
        .out_overrun   (out_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues updated from the rules of each path
    logic [DATA_W-1:0] m_in[$];
    logic [DATA_W-1:0] m_out[$];
    bit m_under = 0;
    bit m_over  = 0;
    bit m_in_ready, m_in_pop, m_in_push, m_out_pop, m_out_push, m_under_set, m_over_set;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in.delete();
            m_out.delete();
            m_under = 0;
            m_over  = 0;
        end else begin
            m_in_ready  = (m_in.size() != DEPTH);
            m_in_pop    = io_rd && (m_in.size() != 0);
            m_under_set = io_rd && (m_in.size() == 0);
            m_in_push   = ext_in_valid && m_in_ready;
            m_out_pop   = (m_out.size() != 0) && ext_out_ready;
            m_out_push  = io_wr && ((m_out.size() != DEPTH) || m_out_pop);
            m_over_set  = io_wr && !m_out_push;
            if (m_in_pop)   void'(m_in.pop_front());
            if (m_in_push)  m_in.push_back(ext_in_data);
            if (m_out_pop)  void'(m_out.pop_front());
            if (m_out_push) m_out.push_back(wdata);
            m_under = m_under_set || (m_under && !clr_flags);
            m_over  = m_over_set  || (m_over  && !clr_flags);
        end
    end

    always @(negedge clk) begin
        chk("cmp_rdata", int'(rdata), (m_in.size() != 0) ? int'(m_in[0]) : 0);
        chk("cmp_in_count", int'(in_count), m_in.size());
        chk("cmp_in_ready", int'(ext_in_ready), int'(m_in.size() != DEPTH));
        chk("cmp_out_data", int'(ext_out_data), (m_out.size() != 0) ? int'(m_out[0]) : 0);
        chk("cmp_out_count", int'(out_count), m_out.size());
        chk("cmp_out_valid", int'(ext_out_valid), int'(m_out.size() != 0));
        chk("cmp_underrun", int'(in_underrun), int'(m_under));
        chk("cmp_overrun", int'(out_overrun), int'(m_over));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12 rst = 1'b0;
        step();

        chk("rst_in_ready", int'(ext_in_ready), 1);
        chk("rst_out_valid", int'(ext_out_valid), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_in_count", int'(in_count), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_flags", int'({in_underrun, out_overrun}), 0);

        // Three words in, three IN reads, then an underrun
        ext_in_valid = 1'b1;
        ext_in_data = 16'h1111; step();
        ext_in_data = 16'h2222; step();
        ext_in_data = 16'h3333; step();
        ext_in_valid = 1'b0;
        chk("fill3_count", int'(in_count), 3);
        chk("fill3_head", int'(rdata), 16'h1111);
        io_rd = 1'b1;
        step();
        chk("rd1_count", int'(in_count), 2);
        chk("rd1_data", int'(rdata), 16'h2222);
        step();
        chk("rd2_count", int'(in_count), 1);
        chk("rd2_data", int'(rdata), 16'h3333);
        step();
        chk("rd3_count", int'(in_count), 0);
        chk("rd3_data", int'(rdata), 0);
        step();
        io_rd = 1'b0;
        chk("under_flag", int'(in_underrun), 1);
        chk("under_rdata", int'(rdata), 0);
        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        chk("under_clr", int'(in_underrun), 0);

        // Fill input FIFO, hold a fifth word pending, free one slot
        ext_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ext_in_data = 16'h4000 + 16'(i);
            step();
        end
        chk("infull_count", int'(in_count), 4);
        chk("infull_ready", int'(ext_in_ready), 0);
        io_rd = 1'b1; step(); io_rd = 1'b0;
        chk("infree_count", int'(in_count), 3);
        chk("infree_ready", int'(ext_in_ready), 1);
        chk("infree_head", int'(rdata), 16'h4001);
        step();
        ext_in_valid = 1'b0;
        chk("pending_count", int'(in_count), 4);
        io_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("indrain_data", int'(rdata), 16'h4001 + i);
            step();
        end
        io_rd = 1'b0;
        chk("indrain_empty", int'(in_count), 0);

        // Output overrun: five writes while the device stalls
        io_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = 16'hA000 + 16'(i);
            step();
        end
        io_wr = 1'b0;
        chk("over_count", int'(out_count), 4);
        chk("over_flag", int'(out_overrun), 1);
        step();
        chk("stall_hold", int'(ext_out_data), 16'hA000);
        ext_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drainA_valid", int'(ext_out_valid), 1);
            chk("drainA_data", int'(ext_out_data), 16'hA000 + i);
            step();
        end
        chk("drainA_done", int'(ext_out_valid), 0);
        ext_out_ready = 1'b0;
        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        chk("over_clr", int'(out_overrun), 0);

        // Pass-through write at full
        io_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wdata = 16'hB000 + 16'(i);
            step();
        end
        ext_out_ready = 1'b1;
        wdata = 16'hBEEF;
        step();
        io_wr = 1'b0;
        chk("pass_count", int'(out_count), 4);
        chk("pass_no_over", int'(out_overrun), 0);
        for (int i = 1; i < 4; i++) begin
            chk("drainB_data", int'(ext_out_data), 16'hB000 + i);
            step();
        end
        chk("drainB_last", int'(ext_out_data), 16'hBEEF);
        step();
        chk("drainB_done", int'(out_count), 0);
        ext_out_ready = 1'b0;

        // Asynchronous reset mid-drain with words queued on both sides
        io_wr = 1'b1;
        ext_in_valid = 1'b1;
        ext_in_data = 16'hD000;
        for (int i = 0; i < 3; i++) begin
            wdata = 16'hC000 + 16'(i);
            step();
        end
        io_wr = 1'b0;
        ext_in_valid = 1'b0;
        ext_out_ready = 1'b1;
        step();
        chk("mid_count", int'(out_count), 2);
        chk("mid_data", int'(ext_out_data), 16'hC001);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_count", int'(out_count), 0);
        chk("arst_in_count", int'(in_count), 0);
        chk("arst_valid", int'(ext_out_valid), 0);
        chk("arst_out_data", int'(ext_out_data), 0);
        chk("arst_rdata", int'(rdata), 0);
        #4 rst = 1'b0;
        ext_out_ready = 1'b0;
        step();
        chk("post_rst_count", int'(out_count), 0);

        // Simultaneous push and IN read on an empty input FIFO, with an OUT write
        ext_in_valid = 1'b1;
        ext_in_data = 16'h5A5A;
        io_rd = 1'b1;
        io_wr = 1'b1;
        wdata = 16'h7777;
        step();
        ext_in_valid = 1'b0;
        io_rd = 1'b0;
        io_wr = 1'b0;
        chk("both_in_count", int'(in_count), 1);
        chk("both_underrun", int'(in_underrun), 1);
        chk("both_rdata", int'(rdata), 16'h5A5A);
        chk("both_out_data", int'(ext_out_data), 16'h7777);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
